// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one requester port of the memory arbiter (request out, ack/read data back)
interface mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port memory between CPU and DMA; CPU priority, DMA forced after STARVE_MAX lost grants
module mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_arbiter_if.slave      cpu,
    mem_arbiter_if.slave      dma,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt_dma
);
    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    state_t            state_q, state_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              we_q, we_d;
    logic              gnt_dma_q, gnt_dma_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              pick_dma;
    logic              starved;
    assign starved  = starve_q == SW'(STARVE_MAX);
    assign pick_dma = dma.req & (~cpu.req | starved);
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        we_d        = we_q;
        gnt_dma_d   = gnt_dma_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        case (state_q)
            IDLE: if (pick_dma | cpu.req) begin
                state_d     = ACCESS;
                gnt_dma_d   = pick_dma;
                we_d        = pick_dma ? dma.we : cpu.we;
                mem_addr_d  = pick_dma ? dma.addr : cpu.addr;
                mem_wdata_d = pick_dma ? dma.wdata : cpu.wdata;
                mem_en_d    = 1'b1;
                mem_we_d    = we_d;
                starve_d    = pick_dma ? '0 : (dma.req & ~starved) ? starve_q + SW'(1) : starve_q;
            end
            ACCESS: begin
                state_d = WAIT;
                lat_d   = LW'(MEM_LAT);
            end
            WAIT: begin
                lat_d = lat_q - LW'(1);
                if (lat_q == LW'(1)) begin
                    state_d     = DONE;
                    cpu_ack_d   = ~gnt_dma_q;
                    dma_ack_d   = gnt_dma_q;
                    cpu_rdata_d = (~we_q & ~gnt_dma_q) ? mem_rdata : cpu_rdata_q;
                    dma_rdata_d = (~we_q & gnt_dma_q) ? mem_rdata : dma_rdata_q;
                end
            end
            DONE: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            starve_q    <= '0;
            we_q        <= 1'b0;
            gnt_dma_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            we_q        <= we_d;
            gnt_dma_q   <= gnt_dma_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign gnt_dma   = gnt_dma_q;
    assign cpu.ack   = cpu_ack_q;
    assign cpu.rdata = cpu_rdata_q;
    assign dma.ack   = dma_ack_q;
    assign dma.rdata = dma_rdata_q;
endmodule
